operand_entry_ctrl: RTL and testbench

- Sequencer that sits between the keypad scanner/debouncer and the arithmetic/display datapath.
- Consumes decoded key events through a valid/ack handshake and builds two multi-digit BCD operands (A, then B).
- `*` means clear and `#` means enter.
- Presents the finished operand pair downstream through a valid/ready handshake, and exposes the operand being typed for the display.

---
 rtl/entry_pkg.sv | 17 +
 rtl/operand_entry_ctrl_if.sv | 29 ++
 rtl/bcd_shift_acc.sv | 36 +++
 rtl/operand_entry_ctrl.sv | 110 +++++++++++
 tb/tb_operand_entry_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/entry_pkg.sv
// Shared types and key codes for the operand entry sequencer.
package entry_pkg;
    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_STAR = 4'd10;
    localparam key_code_t KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        ENTRY_A = 2'd0,
        ENTRY_B = 2'd1,
        HOLD    = 2'd2
    } entry_state_t;

    function automatic logic is_digit(key_code_t c);
        return c <= 4'd9;
    endfunction
endpackage

// File: rtl/operand_entry_ctrl_if.sv
// Key-event and operand handshake bundle. slave = the entry sequencer,
// master = the keypad reader / datapath side.
interface operand_entry_ctrl_if import entry_pkg::*; #(
    parameter int DIGITS = 3
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic            key_valid;
    key_code_t       key_code;
    logic            key_ack;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic            op_valid;
    logic            op_ready;
    logic [W-1:0]    disp_bcd;
    logic [CW-1:0]   digit_cnt;
    logic [1:0]      phase;

    modport slave (
        input  key_valid, key_code, op_ready,
        output key_ack, op_a, op_b, op_valid, disp_bcd, digit_cnt, phase
    );

    modport master (
        output key_valid, key_code, op_ready,
        input  key_ack, op_a, op_b, op_valid, disp_bcd, digit_cnt, phase
    );
endinterface

// File: rtl/bcd_shift_acc.sv
// One packed-BCD operand register with its digit count. New digits shift
// in at the least-significant nibble; the owner gates loads with 'full'.
module bcd_shift_acc #(
    parameter int DIGITS = 3,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_digit,
    input  logic                clear,
    input  logic [3:0]          digit,
    output logic [4*DIGITS-1:0] value,
    output logic [CW-1:0]       cnt,
    output logic                full
);
    localparam int W = 4 * DIGITS;

    logic [W+3:0] shifted;

    assign shifted = {value, digit};
    assign full    = (cnt == CW'(DIGITS));

    // Clear wins over load; loads are only issued while not full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            cnt   <= '0;
        end else if (clear) begin
            value <= '0;
            cnt   <= '0;
        end else if (load_digit) begin
            value <= shifted[W-1:0];
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/operand_entry_ctrl.sv
// Keypad operand entry sequencer: builds BCD operands A then B from key
// events ('*' clear, '#' enter) and hands the pair downstream.
// Optional: define ENTRY_TIMEOUT_EN to abandon entry after TIMEOUT_CYCLES
// of inactivity in ENTRY_A/ENTRY_B.
module operand_entry_ctrl import entry_pkg::*; #(
    parameter int DIGITS         = 3,
    parameter int TIMEOUT_CYCLES = 27_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_entry_ctrl_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    entry_state_t  state;
    logic          key_ack_q;
    logic          op_valid_q;
    logic          accept;
    logic          release_hold;
    logic          timeout;
    logic          is_num, is_star, is_hash;
    logic          ld_a, ld_b, clr_a, clr_b;
    logic [W-1:0]  a_val, b_val;
    logic [CW-1:0] a_cnt, b_cnt;
    logic          a_full, b_full;

    // Events seen during the ack cycle are the same event; never re-accept.
    assign accept       = bus.key_valid && !key_ack_q && (state != HOLD);
    assign release_hold = (state == HOLD) && op_valid_q && bus.op_ready;
    assign is_num       = is_digit(bus.key_code);
    assign is_star      = (bus.key_code == KEY_STAR);
    assign is_hash      = (bus.key_code == KEY_HASH);

    // Digits past the limit are still acked, just not stored.
    assign ld_a  = accept && is_num && (state == ENTRY_A) && !a_full;
    assign ld_b  = accept && is_num && (state == ENTRY_B) && !b_full;
    // '*' on an empty B falls back to A, so A is cleared in that case too.
    assign clr_a = (accept && is_star && (state == ENTRY_A ||
                   (state == ENTRY_B && b_cnt == '0))) || release_hold || timeout;
    assign clr_b = (accept && is_star && state == ENTRY_B) || release_hold || timeout;

    bcd_shift_acc #(.DIGITS(DIGITS), .CW(CW)) u_acc_a (
        .clk(clk), .rst_n(rst_n), .load_digit(ld_a), .clear(clr_a),
        .digit(bus.key_code), .value(a_val), .cnt(a_cnt), .full(a_full)
    );

    bcd_shift_acc #(.DIGITS(DIGITS), .CW(CW)) u_acc_b (
        .clk(clk), .rst_n(rst_n), .load_digit(ld_b), .clear(clr_b),
        .digit(bus.key_code), .value(b_val), .cnt(b_cnt), .full(b_full)
    );

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    assign timeout = (state != HOLD) && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Inactivity counter: reloads on activity, frozen while holding a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (accept || release_hold || timeout)
            idle_cnt <= '0;
        else if (state != HOLD)
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    // Without the feature entry waits forever; the parameter is inert.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Entry FSM with registered ack and op_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ENTRY_A;
            key_ack_q  <= 1'b0;
            op_valid_q <= 1'b0;
        end else begin
            key_ack_q <= accept;
            if (timeout) begin
                state <= ENTRY_A;
            end else if (release_hold) begin
                state      <= ENTRY_A;
                op_valid_q <= 1'b0;
            end else if (accept) begin
                case (state)
                    ENTRY_A: if (is_hash) state <= ENTRY_B;
                    ENTRY_B: begin
                        if (is_hash) begin
                            state      <= HOLD;
                            op_valid_q <= 1'b1;
                        end else if (is_star && b_cnt == '0) begin
                            state <= ENTRY_A;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

    assign bus.key_ack   = key_ack_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.op_a      = a_val;
    assign bus.op_b      = b_val;
    assign bus.disp_bcd  = (state == ENTRY_A) ? a_val : b_val;
    assign bus.digit_cnt = (state == ENTRY_A) ? a_cnt : b_cnt;
    assign bus.phase     = state;
endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl (DIGITS=3, default build).
module tb_operand_entry_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   ack_cnt = 0;
    int   ack_base;

    operand_entry_ctrl_if #(.DIGITS(3)) bus ();

    operand_entry_ctrl #(.DIGITS(3), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Count cycles in which key_ack is high.
    always @(posedge clk) if (bus.key_ack === 1'b1) ack_cnt <= ack_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Producer model: raise the event, drop it once the ack is seen.
    task automatic press(input logic [3:0] c);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        tick();
        check("press_ack", 32'(bus.key_ack), 32'd1);
        bus.key_valid = 1'b0;
        tick();
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.op_ready  = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_op_a", 32'(bus.op_a), 32'h0);
        check("rst_op_b", 32'(bus.op_b), 32'h0);
        check("rst_op_valid", 32'(bus.op_valid), 32'h0);
        check("rst_key_ack", 32'(bus.key_ack), 32'h0);
        check("rst_digit_cnt", 32'(bus.digit_cnt), 32'h0);
        check("rst_phase", 32'(bus.phase), 32'h0);
        check("rst_disp", 32'(bus.disp_bcd), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1,2,3,#,4,5,# then ready
        press(4'd1); press(4'd2); press(4'd3);
        check("a123", 32'(bus.op_a), 32'h123);
        check("a123_cnt", 32'(bus.digit_cnt), 32'd3);
        check("a123_disp", 32'(bus.disp_bcd), 32'h123);
        press(4'd11);
        check("hashA_phase", 32'(bus.phase), 32'd1);
        check("hashA_cnt", 32'(bus.digit_cnt), 32'd0);
        press(4'd4); press(4'd5);
        check("b045", 32'(bus.op_b), 32'h045);
        check("b045_disp", 32'(bus.disp_bcd), 32'h045);
        check("b045_cnt", 32'(bus.digit_cnt), 32'd2);
        press(4'd11);
        check("hold_phase", 32'(bus.phase), 32'd2);
        check("hold_valid", 32'(bus.op_valid), 32'd1);
        tick(); tick();
        check("hold_valid_kept", 32'(bus.op_valid), 32'd1);
        check("hold_a_frozen", 32'(bus.op_a), 32'h123);
        check("hold_b_frozen", 32'(bus.op_b), 32'h045);
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
        check("rel_valid", 32'(bus.op_valid), 32'd0);
        check("rel_a", 32'(bus.op_a), 32'h0);
        check("rel_b", 32'(bus.op_b), 32'h0);
        check("rel_phase", 32'(bus.phase), 32'd0);
        check("rel_cnt", 32'(bus.digit_cnt), 32'd0);

        // Overflow: fourth digit acked and discarded
        ack_base = ack_cnt;
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        check("ovf_a", 32'(bus.op_a), 32'h987);
        check("ovf_cnt", 32'(bus.digit_cnt), 32'd3);
        check("ovf_acks", 32'(ack_cnt - ack_base), 32'd4);
        press(4'd13);
        check("invalid_a", 32'(bus.op_a), 32'h987);
        check("invalid_phase", 32'(bus.phase), 32'd0);

        // Clear behaviour
        press(4'd10);
        check("starA_a", 32'(bus.op_a), 32'h0);
        check("starA_cnt", 32'(bus.digit_cnt), 32'd0);
        press(4'd1); press(4'd11);
        press(4'd10);
        check("starBempty_phase", 32'(bus.phase), 32'd0);
        check("starBempty_a", 32'(bus.op_a), 32'h0);
        press(4'd1); press(4'd11); press(4'd7);
        check("b007", 32'(bus.op_b), 32'h007);
        press(4'd10);
        check("starB_b", 32'(bus.op_b), 32'h0);
        check("starB_phase", 32'(bus.phase), 32'd1);
        check("starB_cnt", 32'(bus.digit_cnt), 32'd0);
        check("starB_a_kept", 32'(bus.op_a), 32'h001);
        press(4'd10);
        check("starB2_phase", 32'(bus.phase), 32'd0);

        // key_valid held up to 5 cycles; producer clears after seeing ack
        ack_base = ack_cnt;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.key_ack === 1'b1) bus.key_valid = 1'b0;
        end
        bus.key_valid = 1'b0;
        tick();
        check("held_acks", 32'(ack_cnt - ack_base), 32'd1);
        check("held_a", 32'(bus.op_a), 32'h005);
        check("held_cnt", 32'(bus.digit_cnt), 32'd1);

        // Pending key while in HOLD
        press(4'd11); press(4'd11);
        check("hold2_valid", 32'(bus.op_valid), 32'd1);
        ack_base = ack_cnt;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd2;
        tick(); tick(); tick();
        check("hold_no_ack", 32'(bus.key_ack), 32'd0);
        check("hold_ack_cnt", 32'(ack_cnt - ack_base), 32'd0);
        check("hold_a_kept", 32'(bus.op_a), 32'h005);
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
        check("hold_rel_phase", 32'(bus.phase), 32'd0);
        check("hold_rel_ack", 32'(bus.key_ack), 32'd0);
        tick();
        check("pend_ack", 32'(bus.key_ack), 32'd1);
        check("pend_a", 32'(bus.op_a), 32'h002);
        bus.key_valid = 1'b0;
        tick();

        // Asynchronous reset in HOLD
        press(4'd3); press(4'd11); press(4'd11);
        check("hold3_valid", 32'(bus.op_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.op_valid), 32'd0);
        check("arst_a", 32'(bus.op_a), 32'h0);
        check("arst_b", 32'(bus.op_b), 32'h0);
        check("arst_phase", 32'(bus.phase), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_phase", 32'(bus.phase), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
